// File: rtl/ws2812_frame_sched_if.sv
// rtl/ws2812_frame_sched_if.sv - picosoc iomem request/response bundle for ws2812_frame_sched
interface ws2812_frame_sched_if;
    logic        sel;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;

    modport master (
        output sel, iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        input  iomem_ready, iomem_rdata
    );

    modport slave (
        input  sel, iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        output iomem_ready, iomem_rdata
    );
endinterface

// File: rtl/ws2812_frame_sched.sv
// rtl/ws2812_frame_sched.sv - shadow LED frame streamed to the ws2812 load port on COMMIT
// Optional per-byte brightness scaling is built only when WS2812_BRIGHTNESS_EN is defined.
module ws2812_frame_sched #(
    parameter int          NUM_LEDS  = 8,
    parameter logic [15:0] GAP_RESET = 16'd0
) (
    input  logic                clk,
    input  logic                reset,
    ws2812_frame_sched_if.slave bus,
    output logic [7:0]          led_num,
    output logic [23:0]         led_rgb_data,
    output logic                led_write,
    output logic                busy,
    output logic                done
);
    localparam int               IDX_W      = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_LEDS - 1);
    localparam logic [6:0]       NUM_LEDS_W = 7'(NUM_LEDS);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WRITE, S_GAP, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [15:0]      gap_cnt_q, gap_cnt_d;
    logic             pending_q, pending_d;
    logic             commit_q, commit_d;
    logic [15:0]      gap_q, gap_d;
    logic             ready_q, ready_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             led_write_q, led_write_d;
    logic [7:0]       led_num_q, led_num_d;
    logic [23:0]      led_rgb_q, led_rgb_d;
    logic [23:0]      shadow_q [NUM_LEDS];

    logic             shadow_we;
    logic [23:0]      shadow_wdata;
    logic [6:0]       word;
    logic             is_wr, is_ctrl, is_gap, led_hit, req, accept;
    logic [IDX_W-1:0] led_sel;
    logic [23:0]      led_cur;
    logic [23:0]      load_entry;
    logic [23:0]      load_rgb;
    logic             unused_bits;

    assign word    = bus.iomem_addr[8:2];
    assign is_wr   = |bus.iomem_wstrb;
    assign is_ctrl = (word == 7'h00);
    assign is_gap  = (word == 7'h01);
    assign led_hit = word[6] && ({1'b0, word[5:0]} < NUM_LEDS_W);
    assign led_sel = IDX_W'(word[5:0]);
    assign led_cur = shadow_q[led_sel];
    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);

    // Buffer writes wait out the whole pass so a frame is never streamed half-updated.
    assign req    = bus.iomem_valid && bus.sel && !ready_q;
    assign accept = req && !(is_wr && led_hit && busy);

    assign unused_bits = ^{bus.iomem_addr[31:9], bus.iomem_addr[1:0], bus.iomem_wdata[31:24]};

    assign load_entry = shadow_q[idx_q];

`ifdef WS2812_BRIGHTNESS_EN
    logic       is_bright;
    logic [7:0] bright_q, bright_d;

    assign is_bright = (word == 7'h02);

    function automatic logic [7:0] scale8(input logic [7:0] c, input logic [7:0] b);
        logic [15:0] p;
        p = 16'(c) * 16'({1'b0, b} + 9'd1);
        return 8'(p >> 8);
    endfunction

    assign load_rgb = {scale8(load_entry[23:16], bright_q),
                       scale8(load_entry[15:8],  bright_q),
                       scale8(load_entry[7:0],   bright_q)};
`else
    assign load_rgb = load_entry;
`endif

    always_comb begin
        ready_d      = 1'b0;
        rdata_d      = rdata_q;
        commit_d     = 1'b0;
        gap_d        = gap_q;
        shadow_we    = 1'b0;
        shadow_wdata = led_cur;
`ifdef WS2812_BRIGHTNESS_EN
        bright_d     = bright_q;
`endif
        if (accept) begin
            ready_d = 1'b1;
            if (is_wr) begin
                if (is_ctrl) begin
                    commit_d = bus.iomem_wstrb[0] & bus.iomem_wdata[0];
                end
                if (is_gap) begin
                    if (bus.iomem_wstrb[0]) gap_d[7:0]  = bus.iomem_wdata[7:0];
                    if (bus.iomem_wstrb[1]) gap_d[15:8] = bus.iomem_wdata[15:8];
                end
`ifdef WS2812_BRIGHTNESS_EN
                if (is_bright && bus.iomem_wstrb[0]) bright_d = bus.iomem_wdata[7:0];
`endif
                if (led_hit) begin
                    shadow_we = 1'b1;
                    for (int b = 0; b < 3; b++) begin
                        if (bus.iomem_wstrb[b]) shadow_wdata[8*b +: 8] = bus.iomem_wdata[8*b +: 8];
                    end
                end
            end else begin
                rdata_d = 32'd0;
                if (is_ctrl) begin
                    rdata_d = {29'd0, pending_q, busy, 1'b0};
                end else if (is_gap) begin
                    rdata_d = {16'd0, gap_q};
`ifdef WS2812_BRIGHTNESS_EN
                end else if (is_bright) begin
                    rdata_d = {24'd0, bright_q};
`endif
                end else if (led_hit) begin
                    rdata_d = {8'd0, led_cur};
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        gap_cnt_d   = gap_cnt_q;
        pending_d   = pending_q;
        led_write_d = 1'b0;
        led_num_d   = led_num_q;
        led_rgb_d   = led_rgb_q;
        if (commit_q && state_q != S_IDLE && state_q != S_DONE) pending_d = 1'b1;
        unique case (state_q)
            S_IDLE: begin
                if (commit_q) begin
                    state_d = S_LOAD;
                    idx_d   = '0;
                end
            end
            // Outputs are registered here so they are valid exactly while in WRITE.
            S_LOAD: begin
                led_write_d = 1'b1;
                led_num_d   = 8'(idx_q);
                led_rgb_d   = load_rgb;
                state_d     = S_WRITE;
            end
            S_WRITE: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                    if (gap_q != 16'd0) begin
                        state_d   = S_GAP;
                        gap_cnt_d = '0;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_GAP: begin
                if ({1'b0, gap_cnt_q} + 17'd1 >= {1'b0, gap_q}) state_d = S_LOAD;
                else gap_cnt_d = gap_cnt_q + 16'd1;
            end
            S_DONE: begin
                pending_d = 1'b0;
                if (pending_q || commit_q) begin
                    state_d = S_LOAD;
                    idx_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            gap_cnt_q   <= '0;
            pending_q   <= 1'b0;
            commit_q    <= 1'b0;
            gap_q       <= GAP_RESET;
            ready_q     <= 1'b0;
            rdata_q     <= 32'd0;
            led_write_q <= 1'b0;
            led_num_q   <= 8'd0;
            led_rgb_q   <= 24'd0;
`ifdef WS2812_BRIGHTNESS_EN
            bright_q    <= 8'hFF;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            gap_cnt_q   <= gap_cnt_d;
            pending_q   <= pending_d;
            commit_q    <= commit_d;
            gap_q       <= gap_d;
            ready_q     <= ready_d;
            rdata_q     <= rdata_d;
            led_write_q <= led_write_d;
            led_num_q   <= led_num_d;
            led_rgb_q   <= led_rgb_d;
`ifdef WS2812_BRIGHTNESS_EN
            bright_q    <= bright_d;
`endif
        end
    end

    // Shadow frame has no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (shadow_we) shadow_q[led_sel] <= shadow_wdata;
    end

    assign bus.iomem_ready = ready_q;
    assign bus.iomem_rdata = rdata_q;
    assign led_write       = led_write_q;
    assign led_num         = led_num_q;
    assign led_rgb_data    = led_rgb_q;
endmodule

// File: tb/tb_ws2812_frame_sched.sv
// tb/tb_ws2812_frame_sched.sv - scoreboard bench for ws2812_frame_sched
module tb_ws2812_frame_sched;
    localparam int N = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  led_num;
    logic [23:0] led_rgb_data;
    logic        led_write, busy, done;

    always #5 clk = ~clk;

    ws2812_frame_sched_if bus ();

    ws2812_frame_sched #(.NUM_LEDS(N), .GAP_RESET(16'd0)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .led_num(led_num), .led_rgb_data(led_rgb_data), .led_write(led_write),
        .busy(busy), .done(done)
    );

    typedef struct { int cyc; logic [7:0] num; logic [23:0] rgb; } wr_t;
    typedef struct { int pend_from; int start; int done_c; } pass_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    wr_t         exp_wr[$];
    int          exp_done[$];
    pass_t       passes[$];
    logic [23:0] m_shadow [64];
    logic [15:0] m_gap;
    logic [7:0]  m_bright;
    bit          mon_en = 1'b0;
    int          writes_seen = 0;
    int          last_start = 0;
    int          last_done = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] m_scale(input logic [7:0] c);
`ifdef WS2812_BRIGHTNESS_EN
        int p;
        p = int'(c) * (int'(m_bright) + 1);
        return 8'(p / 256);
`else
        return c;
`endif
    endfunction

    function automatic bit model_busy(input int c);
        foreach (passes[i]) if (passes[i].start <= c && c <= passes[i].done_c) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit model_pending(input int c);
        foreach (passes[i]) if (passes[i].pend_from <= c && c < passes[i].start) return 1'b1;
        return 1'b0;
    endfunction

    // A pass runs LOAD,WRITE per LED with GAP idle cycles between LEDs, then one DONE cycle.
    task automatic model_commit(input int t);
        pass_t p;
        int    s;
        int    step;
        wr_t   w;
        if (t >= last_done) begin
            s = t + 1;
            p.pend_from = s;
        end else if (t < last_start) begin
            return;
        end else begin
            s = last_done + 1;
            p.pend_from = t + 1;
        end
        step = 2 + int'(m_gap);
        p.start  = s;
        p.done_c = s + 1 + (N - 1) * step + 1;
        for (int i = 0; i < N; i++) begin
            w.cyc = s + 1 + i * step;
            w.num = 8'(i);
            w.rgb = {m_scale(m_shadow[i][23:16]), m_scale(m_shadow[i][15:8]), m_scale(m_shadow[i][7:0])};
            exp_wr.push_back(w);
        end
        exp_done.push_back(p.done_c);
        passes.push_back(p);
        last_start = s;
        last_done  = p.done_c;
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] addr, input int c);
        logic [6:0] w;
        w = addr[8:2];
        if (w == 7'h00) return {29'd0, model_pending(c), model_busy(c), 1'b0};
        if (w == 7'h01) return {16'd0, m_gap};
`ifdef WS2812_BRIGHTNESS_EN
        if (w == 7'h02) return {24'd0, m_bright};
`endif
        if (w[6] && int'(w[5:0]) < N) return {8'd0, m_shadow[w[5:0]]};
        return 32'd0;
    endfunction

    task automatic xfer(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] wdata,
                        output logic [31:0] rdata, output int ack);
        int req;
        int exp_ack;
        bit got;
        bit stallable;
        got = 1'b0;
        @(negedge clk);
        bus.sel         = 1'b1;
        bus.iomem_valid = 1'b1;
        bus.iomem_addr  = addr;
        bus.iomem_wstrb = strb;
        bus.iomem_wdata = wdata;
        req = cyc;
        stallable = (strb != 4'h0) && addr[8] && (int'(addr[7:2]) < N);
        exp_ack = req;
        while (stallable && model_busy(exp_ack)) exp_ack++;
        exp_ack++;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (bus.iomem_ready) begin
                got = 1'b1;
                break;
            end
        end
        rdata = bus.iomem_rdata;
        ack   = cyc;
        bus.iomem_valid = 1'b0;
        bus.sel         = 1'b0;
        bus.iomem_wstrb = 4'h0;
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL bus_timeout: no ready for addr %0h after 400 cycles", addr);
        end else begin
            check("ack_cycle", ack, exp_ack);
        end
    endtask

    task automatic reg_wr(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] d);
        logic [31:0] r;
        int          ack;
        xfer(addr, strb, d, r, ack);
        if (addr[8:2] == 7'h00) begin
            if (strb[0] && d[0]) model_commit(ack);
        end else if (addr[8:2] == 7'h01) begin
            if (strb[0]) m_gap[7:0]  = d[7:0];
            if (strb[1]) m_gap[15:8] = d[15:8];
        end else if (addr[8:2] == 7'h02) begin
`ifdef WS2812_BRIGHTNESS_EN
            if (strb[0]) m_bright = d[7:0];
`endif
        end else if (addr[8] && int'(addr[7:2]) < N) begin
            for (int b = 0; b < 3; b++) if (strb[b]) m_shadow[addr[7:2]][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    task automatic rd_check(input string name, input logic [31:0] addr);
        logic [31:0] r;
        int          ack;
        xfer(addr, 4'h0, 32'h0, r, ack);
        check(name, r, m_read(addr, ack - 1));
    endtask

    task automatic wait_idle();
        int lim;
        lim = cyc + 3000;
        while (cyc <= last_done + 1 && cyc < lim) @(negedge clk);
    endtask

    task automatic commit();
        reg_wr(32'h0400_0000, 4'h1, 32'h1);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check("busy", 32'(busy), 32'(model_busy(cyc)));
            if (led_write) begin
                writes_seen++;
                if (exp_wr.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_led_write: got num %0d at cycle %0d, expected none", led_num, cyc);
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    check("led_write_cycle", cyc, e.cyc);
                    check("led_num", 32'(led_num), 32'(e.num));
                    check("led_rgb_data", 32'(led_rgb_data), 32'(e.rgb));
                end
            end
            if (done) begin
                if (exp_done.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
                end else begin
                    check("done_cycle", cyc, exp_done.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_done;
        int target;
        bit reached;
        reset           = 1'b1;
        bus.sel         = 1'b0;
        bus.iomem_valid = 1'b0;
        bus.iomem_wstrb = 4'h0;
        bus.iomem_addr  = 32'h0;
        bus.iomem_wdata = 32'h0;
        m_gap    = 16'd0;
        m_bright = 8'hFF;
        repeat (3) @(negedge clk);
        check("rst_led_write", 32'(led_write), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(bus.iomem_ready), 32'd0);
        check("rst_rdata", bus.iomem_rdata, 32'd0);
        reset  = 1'b0;
        mon_en = 1'b1;
        rd_check("rst_ctrl", 32'h0400_0000);
        rd_check("rst_gap", 32'h0400_0004);
        rd_check("rst_bright", 32'h0400_0008);

        // Basic frame 0x010203*i, GAP=0
        for (int i = 0; i < N; i++) reg_wr(32'h0400_0100 + 32'(4 * i), 4'hF, 32'h0001_0203 * 32'(i));
        for (int i = 0; i < N; i++) rd_check("led_readback", 32'h0400_0100 + 32'(4 * i));
        commit();
        wait_idle();

        // Reset after the third pulse of a pass
        target = writes_seen + 3;
        commit();
        reached = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (writes_seen >= target) begin
                reached = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!reached) begin
            n_cmp++;
            n_bad++;
            $display("FAIL midpass_wait: got %0d pulses, expected %0d", writes_seen, target);
        end
        mon_en = 1'b0;
        reset  = 1'b1;
        @(negedge clk);
        check("midrst_led_write", 32'(led_write), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_led_num", 32'(led_num), 32'd0);
        check("midrst_rgb", 32'(led_rgb_data), 32'd0);
        check("midrst_ready", 32'(bus.iomem_ready), 32'd0);
        check("midrst_rdata", bus.iomem_rdata, 32'd0);
        reset = 1'b0;
        exp_wr.delete();
        exp_done.delete();
        passes.delete();
        last_start = 0;
        last_done  = 0;
        m_gap      = 16'd0;
        m_bright   = 8'hFF;
        mon_en     = 1'b1;
        repeat (4) @(negedge clk);

        // GAP=3 with a random frame
        for (int i = 0; i < N; i++) reg_wr(32'h0400_0100 + 32'(4 * i), 4'hF, $urandom);
        reg_wr(32'h0400_0004, 4'h3, 32'd3);
        rd_check("gap_read", 32'h0400_0004);
        commit();
        wait_idle();

        // Buffer write stalls during a pass; CTRL read does not
        commit();
        rd_check("ctrl_during_pass", 32'h0400_0000);
        reg_wr(32'h0400_0108, 4'hF, 32'h00AB_CDEF);
        rd_check("led2_after_stall", 32'h0400_0108);
        commit();
        wait_idle();

        // Two extra COMMITs during a pass merge into one follow-on pass
        reg_wr(32'h0400_0004, 4'h3, 32'd0);
        commit();
        first_done = last_done;
        commit();
        commit();
        rd_check("ctrl_pending", 32'h0400_0000);
        while (cyc < first_done + 2) @(negedge clk);
        rd_check("ctrl_second_pass", 32'h0400_0000);
        wait_idle();
        rd_check("ctrl_idle", 32'h0400_0000);

        // Brightness
        reg_wr(32'h0400_0008, 4'h1, 32'h7F);
        reg_wr(32'h0400_0100, 4'hF, 32'h00FF_8002);
        rd_check("bright_read", 32'h0400_0008);
        commit();
        wait_idle();
        reg_wr(32'h0400_0008, 4'h1, 32'hFF);
        commit();
        wait_idle();

        // Unmapped and out-of-range accesses
        rd_check("unmapped_read", 32'h0400_000C);
        reg_wr(32'h0400_0128, 4'hF, 32'h0012_3456);
        rd_check("oor_led_read", 32'h0400_0128);

        // Randomised frames, strobes, gaps, brightness
        for (int it = 0; it < 6; it++) begin
            reg_wr(32'h0400_0004, 4'h3, 32'($urandom_range(0, 2)));
            reg_wr(32'h0400_0008, 4'h1, $urandom);
            repeat (6) reg_wr(32'h0400_0100 + 32'(4 * $urandom_range(0, 11)),
                              4'($urandom_range(1, 15)), $urandom);
            for (int i = 0; i < N; i++) rd_check("rand_led_read", 32'h0400_0100 + 32'(4 * i));
            rd_check("rand_bright_read", 32'h0400_0008);
            commit();
            if ($urandom_range(0, 1) == 1) commit();
            wait_idle();
        end

        repeat (5) @(negedge clk);
        check("leftover_writes", 32'(exp_wr.size()), 32'd0);
        check("leftover_dones", 32'(exp_done.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
